tx_serializer_10b: RTL and testbench

- Downstream stage of the 8b/10b encoder. It takes 10-bit code groups, sends them out one bit per clock with the 'a' bit first, and sends K28.5 idle commas whenever no data word is ready at a word boundary.
- It keeps its own running disparity (RD) from the weight of each word it transmits. This RD selects the comma polarity and is used to flag disparity and weight errors in incoming words.
- It feeds the line driver / PHY bit interface.

---
 rtl/enc8b10b_pkg.sv | 31 +++
 rtl/rd_tracker.sv | 39 +++
 rtl/tx_serializer_10b.sv | 89 ++++++++
 tb/tb_tx_serializer_10b.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b constants: K28.5 commas, code-group width,
// bit positions (a..j) and a 10-bit popcount helper.
package enc8b10b_pkg;

  localparam int CG_W = 10;

  localparam logic [CG_W-1:0] K28_5_NEG = 10'h17C;
  localparam logic [CG_W-1:0] K28_5_POS = 10'h283;

  localparam int A_BIT = 0;
  localparam int B_BIT = 1;
  localparam int C_BIT = 2;
  localparam int D_BIT = 3;
  localparam int E_BIT = 4;
  localparam int I_BIT = 5;
  localparam int F_BIT = 6;
  localparam int G_BIT = 7;
  localparam int H_BIT = 8;
  localparam int J_BIT = 9;

  function automatic logic [3:0] popcount10(
    input logic [CG_W-1:0] w
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < CG_W; i++)
      n = n + {3'b000, w[i]};
    return n;
  endfunction

endpackage

// File: rtl/rd_tracker.sv
// Running-disparity step for one 10-bit code group.
// Ports: word/load/rd in; rd_next and disp_err (weight/disparity fault) out.
module rd_tracker
  import enc8b10b_pkg::*;
(
  input  logic [CG_W-1:0] word,
  input  logic            load,
  input  logic            rd,
  output logic            rd_next,
  output logic            disp_err
);

  logic [3:0] w;

  always_comb begin
    w        = popcount10(word);
    rd_next  = rd;
    disp_err = 1'b0;
    if (load) begin
      unique case (1'b1)
        (w == 4'd6): begin
          rd_next  = 1'b1;
          disp_err = rd;
        end
        (w == 4'd4): begin
          rd_next  = 1'b0;
          disp_err = !rd;
        end
        (w == 4'd5): begin
          rd_next  = rd;
        end
        default: begin
          disp_err = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/tx_serializer_10b.sv
// 10-bit code-group serializer, 'a' bit first, K28.5 idle fill.
// Ports: clk, rst, din/din_valid/din_ready in; sout, word_start,
// comma_sent, rd_out, disp_err out.
module tx_serializer_10b
  import enc8b10b_pkg::*;
#(
  parameter logic [CG_W-1:0] COMMA_NEG = K28_5_NEG,
  parameter logic [CG_W-1:0] COMMA_POS = K28_5_POS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CG_W-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic            sout,
  output logic            word_start,
  output logic            comma_sent,
  output logic            rd_out,
  output logic            disp_err
);

  logic [CG_W-1:0] sreg;
  logic [CG_W-1:0] hold;
  logic [CG_W-1:0] nxt_word;
  logic [3:0]      bit_cnt;
  logic            hold_valid;
  logic            load;
  logic            xfer;
  logic            word_err;

  // rd is the disparity at the start of the word on the line
  // (what rd_out reports); rd_end is the disparity after it,
  // which picks the next comma and judges the next word.
  logic            rd;
  logic            rd_end;
  logic            rd_end_nxt;

  assign load       = (bit_cnt == 4'd9);
  assign din_ready  = !hold_valid || load;
  assign xfer       = din_valid && din_ready;
  assign sout       = sreg[A_BIT];
  assign word_start = (bit_cnt == 4'd0);
  assign rd_out     = rd;

  assign nxt_word = hold_valid ? hold
                  : (rd_end ? COMMA_POS : COMMA_NEG);

  rd_tracker u_rd (
    .word     (nxt_word),
    .load     (load),
    .rd       (rd_end),
    .rd_next  (rd_end_nxt),
    .disp_err (word_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg       <= COMMA_NEG;
      bit_cnt    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      rd         <= 1'b0;
      // the reset comma (weight 6) leaves the line positive
      rd_end     <= 1'b1;
      disp_err   <= 1'b0;
      comma_sent <= 1'b1;
    end else begin
      disp_err <= 1'b0;
      if (load) begin
        sreg       <= nxt_word;
        comma_sent <= !hold_valid;
        disp_err   <= hold_valid && word_err;
        rd         <= rd_end;
        rd_end     <= rd_end_nxt;
        bit_cnt    <= '0;
      end else begin
        sreg    <= {1'b0, sreg[CG_W-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (xfer) begin
        hold       <= din;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Randomized bench for tx_serializer_10b against a word-level
// line model (RD from $countones of each word sent).
module tb_tx_serializer_10b;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       word_start;
  logic       comma_sent;
  logic       rd_out;
  logic       disp_err;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tx_serializer_10b dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .word_start (word_start),
    .comma_sent (comma_sent),
    .rd_out     (rd_out),
    .disp_err   (disp_err)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // line model: current word, bit position, pending words,
  // RD at the start of the current word
  logic [9:0] m_word;
  int         m_pos;
  logic [9:0] m_q[$];
  bit         m_rd;
  bit         m_comma;
  bit         m_err;

  function automatic bit rd_after(bit rd, logic [9:0] w);
    int n = $countones(w);
    if (n == 6) return 1'b1;
    if (n == 4) return 1'b0;
    return rd;
  endfunction

  function automatic bit bad(bit rd, logic [9:0] w);
    int n = $countones(w);
    return (n < 4) || (n > 6) || (n == 6 && rd) || (n == 4 && !rd);
  endfunction

  function automatic logic [9:0] comma(bit rd);
    return rd ? 10'h283 : 10'h17C;
  endfunction

  function automatic bit m_ready();
    return (m_q.size() == 0) || (m_pos == 9);
  endfunction

  task automatic m_reset();
    m_word  = 10'h17C;
    m_pos   = 0;
    m_q.delete();
    m_rd    = 1'b0;
    m_comma = 1'b1;
    m_err   = 1'b0;
  endtask

  task automatic check_all();
    chk("sout", sout, m_word[m_pos]);
    chk("word_start", word_start, m_pos == 0);
    chk("comma_sent", comma_sent, m_comma);
    chk("rd_out", rd_out, m_rd);
    chk("disp_err", disp_err, m_err);
    chk("din_ready", din_ready, m_ready());
  endtask

  task automatic step(bit v, logic [9:0] d);
    bit xfer;
    bit re;
    din_valid = v;
    din       = d;
    xfer      = v && m_ready();
    @(posedge clk);
    cyc++;
    if (m_pos == 9) begin
      re = rd_after(m_rd, m_word);
      if (m_q.size() > 0) begin
        m_word  = m_q.pop_front();
        m_comma = 1'b0;
        m_err   = bad(re, m_word);
      end else begin
        m_word  = comma(re);
        m_comma = 1'b1;
        m_err   = 1'b0;
      end
      m_rd  = re;
      m_pos = 0;
    end else begin
      m_pos++;
      m_err = 1'b0;
    end
    if (xfer) m_q.push_back(d);
    #1 check_all();
  endtask

  // hold din valid until the DUT (per model) takes it
  task automatic send(logic [9:0] d);
    bit r;
    for (int k = 0; k < 40; k++) begin
      r = m_ready();
      step(1'b1, d);
      if (r) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("rst_sout", sout, 0);
    chk("rst_word_start", word_start, 1);
    chk("rst_din_ready", din_ready, 1);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_comma", comma_sent, 1);
    chk("rst_disp_err", disp_err, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    check_all();
  endtask

  logic [39:0] bits;
  logic [9:0]  pat[4];
  logic [9:0]  rw;
  int          idx;
  bit          hit;

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    m_reset();
    #12;
    chk("por_word_start", word_start, 1);
    chk("por_sout", sout, 0);
    @(negedge clk);
    rst = 1'b0;
    check_all();

    // idle: commas alternate
    for (int i = 0; i < 40; i++) begin
      bits[i] = sout;
      step(1'b0, '0);
    end
    chk("idle_w0", bits[9:0], 10'h17C);
    chk("idle_w1", bits[19:10], 10'h283);
    chk("idle_w2", bits[29:20], 10'h17C);
    chk("idle_w3", bits[39:30], 10'h283);

    // single word in cycle 0
    do_reset();
    chk("w155_ready", din_ready, 1);
    step(1'b1, 10'h155);
    for (int i = 0; i < 9; i++) step(1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      chk("w155_bit", sout, (i % 2 == 0));
      chk("w155_rd", rd_out, 1);
      step(1'b0, '0);
    end
    chk("w155_next", comma_sent, 1);

    // back-to-back stream
    do_reset();
    pat[0] = 10'h155; pat[1] = 10'h2AA;
    pat[2] = 10'h155; pat[3] = 10'h2AA;
    idx = 0;
    while (idx < 4 && cyc < 100) begin
      hit = m_ready();
      step(1'b1, pat[idx]);
      if (hit) idx++;
      if (cyc >= 10) chk("stream_data", comma_sent, 0);
    end
    chk("stream_done", idx, 4);
    for (int i = 0; i < 30; i++) step(1'b0, '0);

    // disparity / weight errors
    do_reset();
    send(10'h03F);
    send(10'h3FF);
    while (cyc < 10) step(1'b0, '0);
    chk("e03f_err", disp_err, 1);
    chk("e03f_rd", rd_out, 1);
    chk("e03f_ws", word_start, 1);
    step(1'b0, '0);
    chk("e03f_pulse", disp_err, 0);
    while (cyc < 20) step(1'b0, '0);
    chk("e3ff_err", disp_err, 1);
    chk("e3ff_rd", rd_out, 1);
    while (cyc < 30) step(1'b0, '0);
    chk("e3ff_after_rd", rd_out, 1);
    chk("e3ff_comma", comma_sent, 1);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rw = 10'($urandom_range(0, 1023));
      step($urandom_range(0, 3) != 0, rw);
    end

    // reset mid-word with hold full
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_pos == 4 && !m_comma && m_q.size() == 1)
        hit = 1'b1;
      else
        step(1'b1, 10'h2AA);
    end
    chk("mid_reached", hit, 1);
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
